// File: rtl/spi_flash_writer.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_writer
// Description : Programs one 32-bit word into SPI NOR flash: WREN, PAGE
//               PROGRAM (addr + 4 data bytes, little-endian), then polls
//               READ STATUS until WIP clears or the poll budget runs out.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_writer #(
    parameter int unsigned CS_GAP   = 4,      // must be >= 1
    parameter int unsigned POLL_MAX = 65535   // must be 1..65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  status,
    output logic        CLK,
    output logic        CS_N,
    output logic        MOSI,
    input  logic        MISO
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WREN = 3'd1,
        S_PROG = 3'd2,
        S_POLL = 3'd3,
        S_GAP  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    localparam int c_GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(CS_GAP - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);
    localparam logic [15:0] c_POLL_MAX = 16'(POLL_MAX);
    localparam logic [63:0] c_FRAME_WREN = {8'h06, 56'd0};
    localparam logic [63:0] c_FRAME_POLL = {8'h05, 56'd0};
    // Index of the final high-phase cycle for each transaction length.
    localparam logic [6:0] c_LAST_WREN = 7'd15;
    localparam logic [6:0] c_LAST_PROG = 7'd127;
    localparam logic [6:0] c_LAST_POLL = 7'd31;

    state_t               r_state, w_state_nxt, w_load_state;
    logic [6:0]           r_cyc, w_cyc_nxt;
    logic [6:0]           r_last, w_last_nxt, w_load_last;
    logic [62:0]          r_sh, w_sh_nxt;
    logic [6:0]           r_rx, w_rx_nxt;
    logic [c_GAP_W-1:0]   r_gap, w_gap_nxt;
    logic                 r_to_prog, w_to_prog_nxt;
    logic [15:0]          r_polls, w_polls_nxt, w_polls_inc;
    logic [23:0]          r_addr, w_addr_nxt;
    logic [31:0]          r_wdata, w_wdata_nxt;
    logic [7:0]           r_status, w_status_nxt;
    logic                 r_sclk, w_sclk_nxt;
    logic                 r_cs_n, w_cs_n_nxt;
    logic                 r_mosi, w_mosi_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_error, w_error_nxt;
    logic                 w_load;
    logic [63:0]          w_load_frame;
    logic [63:0]          w_prog_frame;

    // Data bytes go out least-significant first to match the reader.
    assign w_prog_frame = {8'h02, r_addr, r_wdata[7:0], r_wdata[15:8],
                           r_wdata[23:16], r_wdata[31:24]};
    assign w_polls_inc  = (r_polls == c_POLL_MAX) ? r_polls : r_polls + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cyc     <= '0;
            r_last    <= '0;
            r_sh      <= '0;
            r_rx      <= '0;
            r_gap     <= '0;
            r_to_prog <= 1'b0;
            r_polls   <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_status  <= '0;
            r_sclk    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cyc     <= w_cyc_nxt;
            r_last    <= w_last_nxt;
            r_sh      <= w_sh_nxt;
            r_rx      <= w_rx_nxt;
            r_gap     <= w_gap_nxt;
            r_to_prog <= w_to_prog_nxt;
            r_polls   <= w_polls_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_status  <= w_status_nxt;
            r_sclk    <= w_sclk_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_mosi    <= w_mosi_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_error   <= w_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cyc_nxt     = r_cyc;
        w_last_nxt    = r_last;
        w_sh_nxt      = r_sh;
        w_rx_nxt      = r_rx;
        w_gap_nxt     = r_gap;
        w_to_prog_nxt = r_to_prog;
        w_polls_nxt   = r_polls;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_status_nxt  = r_status;
        w_sclk_nxt    = 1'b0;
        w_cs_n_nxt    = r_cs_n;
        w_mosi_nxt    = r_mosi;
        w_done_nxt    = 1'b0;
        w_error_nxt   = 1'b0;
        w_load        = 1'b0;
        w_load_state  = S_WREN;
        w_load_frame  = c_FRAME_WREN;
        w_load_last   = c_LAST_WREN;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_addr_nxt  = addr;
                    w_wdata_nxt = wdata;
                    w_polls_nxt = '0;
                    w_load      = 1'b1;
                end
            end
            S_WREN, S_PROG, S_POLL: begin
                if (!r_cyc[0]) begin
                    w_cyc_nxt  = r_cyc + 7'd1;
                    w_sclk_nxt = 1'b1;
                end else begin
                    w_rx_nxt = {r_rx[5:0], MISO};
                    if (r_cyc == r_last) begin
                        w_cs_n_nxt = 1'b1;
                        w_mosi_nxt = 1'b0;
                        w_gap_nxt  = '0;
                        case (r_state)
                            S_WREN: begin
                                w_state_nxt   = S_GAP;
                                w_to_prog_nxt = 1'b1;
                            end
                            S_PROG: begin
                                w_state_nxt   = S_GAP;
                                w_to_prog_nxt = 1'b0;
                            end
                            default: begin
                                w_status_nxt = {r_rx, MISO};
                                w_polls_nxt  = w_polls_inc;
                                if (!MISO) begin
                                    w_state_nxt = S_FIN;
                                    w_done_nxt  = 1'b1;
                                end else if (w_polls_inc == c_POLL_MAX) begin
                                    w_state_nxt = S_FIN;
                                    w_done_nxt  = 1'b1;
                                    w_error_nxt = 1'b1;
                                end else begin
                                    w_state_nxt = S_GAP;
                                end
                            end
                        endcase
                    end else begin
                        w_cyc_nxt  = r_cyc + 7'd1;
                        w_mosi_nxt = r_sh[62];
                        w_sh_nxt   = {r_sh[61:0], 1'b0};
                    end
                end
            end
            S_GAP: begin
                if (r_gap == c_GAP_LAST) begin
                    w_load = 1'b1;
                    if (r_to_prog) begin
                        w_load_state = S_PROG;
                        w_load_frame = w_prog_frame;
                        w_load_last  = c_LAST_PROG;
                    end else begin
                        w_load_state = S_POLL;
                        w_load_frame = c_FRAME_POLL;
                        w_load_last  = c_LAST_POLL;
                    end
                end else begin
                    w_gap_nxt = r_gap + c_GAP_ONE;
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        // Starting a transaction: CS_N falls together with the first low phase.
        if (w_load) begin
            w_state_nxt = w_load_state;
            w_cyc_nxt   = '0;
            w_last_nxt  = w_load_last;
            w_mosi_nxt  = w_load_frame[63];
            w_sh_nxt    = w_load_frame[62:0];
            w_cs_n_nxt  = 1'b0;
        end

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign error  = r_error;
    assign status = r_status;
    assign CLK    = r_sclk;
    assign CS_N   = r_cs_n;
    assign MOSI   = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_flash_writer
// Description : Scoreboard bench for spi_flash_writer with a flash model;
//               two instances (default POLL_MAX and POLL_MAX=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_flash_writer;

    localparam int TB_GAP = 4;

    typedef struct {
        int          nbits;
        logic [63:0] bits;
    } tx_t;

    typedef struct {
        int         inst;
        int         cyc;
        logic [7:0] st;
        logic       er;
    } done_t;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic [1:0]  start_v = 2'b00;
    logic [23:0] addr    = '0;
    logic [31:0] wdata   = '0;
    int          cycle   = 0;
    int          n_cmp   = 0;
    int          n_bad   = 0;
    bit          aborting = 1'b0;

    tx_t        exp_tx_q[$];
    done_t      exp_done_q[$];
    logic [7:0] resp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic void check(input int inst, input string name,
                                  input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL dut%0d %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     inst, name, act, exp, cycle);
        end
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int PMAX = (gi == 0) ? 65535 : 2;
        logic        busy, done, error, sclk, cs_n, mosi;
        logic [7:0]  status;
        logic        miso     = 1'b0;
        logic [63:0] cap      = '0;
        int          nbits    = 0;
        int          gap      = 0;
        bit          prev_csn = 1'b1;
        bit          in_op    = 1'b0;
        bit          polling  = 1'b0;
        logic        mosi_lo  = 1'b0;
        logic [7:0]  cur_resp = '0;
        tx_t         et;
        done_t       ed;

        spi_flash_writer #(.CS_GAP(TB_GAP), .POLL_MAX(PMAX)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start_v[gi]), .addr(addr),
            .wdata(wdata), .busy(busy), .done(done), .error(error),
            .status(status), .CLK(sclk), .CS_N(cs_n), .MOSI(mosi), .MISO(miso)
        );

        // Flash model + monitor, sampled mid-cycle.
        always @(negedge clk) begin
            if (!rst_n) begin
                check(gi, "reset CS_N", cs_n, 1);
                check(gi, "reset CLK", sclk, 0);
                check(gi, "reset MOSI", mosi, 0);
                check(gi, "reset busy", busy, 0);
                check(gi, "reset done", done, 0);
                check(gi, "reset error", error, 0);
                check(gi, "reset status", status, 0);
                in_op = 1'b0;
            end
            check(gi, "error without done", error & ~done, 0);
            if (!cs_n) begin
                if (prev_csn) begin
                    if (in_op) check(gi, "cs gap", gap, TB_GAP);
                    nbits   = 0;
                    cap     = '0;
                    polling = 1'b0;
                end
                if (sclk) begin
                    check(gi, "mosi stable", mosi, mosi_lo);
                    cap = {cap[62:0], mosi};
                    nbits++;
                    if (nbits == 8 && cap[7:0] == 8'h05) begin
                        polling  = 1'b1;
                        cur_resp = (resp_q.size() != 0) ? resp_q.pop_front() : 8'h00;
                    end
                end else begin
                    mosi_lo = mosi;
                    miso = (polling && nbits >= 8 && nbits < 16) ? cur_resp[15 - nbits] : 1'b0;
                end
            end else begin
                check(gi, "clk idle while deselected", sclk, 0);
                miso = 1'b0;
                if (!prev_csn) begin
                    if (!aborting) begin
                        if (exp_tx_q.size() == 0) begin
                            check(gi, "unexpected transaction bits", nbits, 0);
                        end else begin
                            et = exp_tx_q.pop_front();
                            check(gi, "tx length", nbits, et.nbits);
                            check(gi, "tx bytes", cap, et.bits);
                        end
                    end
                    in_op = rst_n;
                    gap   = 0;
                end
                gap++;
            end
            prev_csn = cs_n;

            if (done) begin
                if (exp_done_q.size() == 0 || exp_done_q[0].inst != gi) begin
                    check(gi, "unexpected done", done, 0);
                end else begin
                    ed = exp_done_q.pop_front();
                    check(gi, "done cycle", cycle, ed.cyc);
                    check(gi, "status", status, ed.st);
                    check(gi, "error", error, ed.er);
                    check(gi, "busy at done", busy, 1);
                    check(gi, "transactions left", exp_tx_q.size(), 0);
                    exp_tx_q.delete();
                    in_op = 1'b0;
                end
            end else if (exp_done_q.size() != 0 && exp_done_q[0].inst == gi &&
                         cycle >= exp_done_q[0].cyc) begin
                check(gi, "done missing", done, 1);
                void'(exp_done_q.pop_front());
                exp_tx_q.delete();
                in_op = 1'b0;
            end
        end
    end

    // intr: 0 none, 1 reset at 40th PROG cycle, 2 stray start during PROG
    task automatic run_op(input int inst, input logic [23:0] a, input logic [31:0] d,
                          input int nbusy, input logic [7:0] busy_st,
                          input logic [7:0] fin_st, input bit timeout, input int intr);
        int         pmax;
        int         npoll;
        int         lat;
        int         k;
        logic [7:0] st;
        tx_t        t;
        done_t      e;
        pmax  = (inst == 0) ? 65535 : 2;
        npoll = timeout ? pmax : nbusy + 1;
        st    = fin_st;
        t.nbits = 8;
        t.bits  = 64'h06;
        exp_tx_q.push_back(t);
        if (intr != 1) begin
            t.nbits = 64;
            t.bits  = {8'h02, a, d[7:0], d[15:8], d[23:16], d[31:24]};
            exp_tx_q.push_back(t);
            for (int p = 0; p < npoll; p++) begin
                st = (timeout || p < nbusy) ? busy_st : fin_st;
                resp_q.push_back(st);
                t.nbits = 16;
                t.bits  = 64'h0500;
                exp_tx_q.push_back(t);
            end
        end
        lat = 16 + TB_GAP + 128 + TB_GAP + npoll * 32 + (npoll - 1) * TB_GAP + 1;
        @(negedge clk);
        k = cycle;
        addr  = a;
        wdata = d;
        start_v[inst] = 1'b1;
        if (intr != 1) begin
            e.inst = inst;
            e.cyc  = k + lat;
            e.st   = st;
            e.er   = timeout;
            exp_done_q.push_back(e);
        end
        @(negedge clk);
        start_v[inst] = 1'b0;
        addr  = 24'($urandom);
        wdata = $urandom;
        if (intr == 1) begin
            while (cycle < k + 60) @(negedge clk);
            #1;
            aborting = 1'b1;
            rst_n    = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            exp_tx_q.delete();
            resp_q.delete();
            aborting = 1'b0;
            repeat (30) @(negedge clk);
        end else begin
            if (intr == 2) begin
                while (cycle < k + 80) @(negedge clk);
                start_v[inst] = 1'b1;
                addr = 24'h000100;
                @(negedge clk);
                start_v[inst] = 1'b0;
            end
            for (int w = 0; w < lat + 20 && exp_done_q.size() != 0; w++) @(negedge clk);
            if (exp_done_q.size() != 0) begin
                $display("FAIL dut%0d done queue not drained", inst);
                $fatal(1);
            end
            repeat (TB_GAP + 6) @(negedge clk);
        end
        resp_q.delete();
    endtask

    initial begin
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_op(0, 24'h012345, 32'hDEADBEEF, 0, 8'h01, 8'h00, 1'b0, 0);
        run_op(0, 24'h0ABCDE, 32'h12345678, 3, 8'h03, 8'h02, 1'b0, 0);
        run_op(1, 24'h55AA33, 32'h0F1E2D3C, 0, 8'h01, 8'h00, 1'b1, 0);
        run_op(0, 24'h123456, 32'hCAFEF00D, 1, 8'h81, 8'h40, 1'b0, 2);
        run_op(0, 24'hFEDCBA, 32'hA5A55A5A, 0, 8'h01, 8'h00, 1'b0, 1);
        run_op(0, 24'h012345, 32'hDEADBEEF, 0, 8'h01, 8'h00, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0)
                run_op(0, 24'($urandom), $urandom, int'($urandom_range(0, 3)),
                       8'($urandom) | 8'h01, 8'($urandom) & 8'hFE, 1'b0, 0);
            else
                run_op(1, 24'($urandom), $urandom, int'($urandom_range(0, 1)),
                       8'($urandom) | 8'h01, 8'($urandom) & 8'hFE, 1'b0, 0);
        end
        run_op(1, 24'($urandom), $urandom, 0, 8'($urandom) | 8'h01, 8'h00, 1'b1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global timeout at cycle %0d", cycle);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/spi_flash_writer.md
# spi_flash_writer

Programs one 32-bit word into the external SPI NOR flash, driving the same four flash pins that the flash read path uses. It issues Write Enable (0x06), then Page Program (0x02) with a 24-bit address and four data bytes, then polls Read Status (0x05) until the write-in-progress bit clears. It sits beside the flash reader in the memory-mapped I/O hub. The I/O hub owns pin arbitration: it routes `CLK`/`CS_N`/`MOSI` from this block only while `busy` is high.

## Interface
- `CS_GAP`, default 4: clk cycles `CS_N` is held high between consecutive flash transactions.
- `POLL_MAX`, default 65535: maximum number of status polls before the operation is abandoned with `error`.

Ports:
- `clk` in 1: the single clock. One clock; reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: request a program operation. Sampled only in IDLE.
- `addr` in 24: flash byte address, latched on an accepted `start`.
- `wdata` in 32: data word, latched on an accepted `start`.
- `busy` out 1: high from the cycle after `start` is accepted until the `done` cycle, inclusive.
- `done` out 1: one-cycle pulse at the end of the operation.
- `error` out 1: one-cycle pulse, coincident with `done`, when the poll limit is exhausted.
- `status` out 8: last status byte read from the flash.
- `CLK` out 1: SPI clock, mode 0, idles low.
- `CS_N` out 1: flash chip select, idles high.
- `MOSI` out 1: serial data to the flash, MSB first.
- `MISO` in 1: serial data from the flash.

## Operation
- Reset values, applied asynchronously: state IDLE, `CLK`=0, `CS_N`=1, `MOSI`=0, `busy`=0, `done`=0, `error`=0, `status`=0x00.
- The FSM sequence is IDLE → WREN → GAP → PROG → GAP → POLL → (GAP → POLL)* → FIN → IDLE.
- IDLE: when `start`=1, latch `addr` and `wdata`, clear the poll counter, and go to WREN.
- WREN: shift 8 bits, 0x06.
- PROG: shift 64 bits in this order:
  - 0x02;
  - `addr[23:16]`, `addr[15:8]`, `addr[7:0]`;
  - `wdata[7:0]`, `wdata[15:8]`, `wdata[23:16]`, `wdata[31:24]`.
  - Byte order is little-endian, matching how the flash reader assembles words.
- POLL: shift 8 bits of 0x05, then 8 read bits with `MOSI`=0. The read byte is captured into `status`.
  - `status[0]`=0 → go to FIN.
  - `status[0]`=1 and fewer than `POLL_MAX` polls done → go to GAP, then POLL again.
  - `status[0]`=1 and `POLL_MAX` polls done → go to FIN with the error flag set.
- GAP: hold `CS_N`=1 and `CLK`=0 for `CS_GAP` cycles.
- FIN: one cycle with `done`=1, and `error`=1 if the flag is set; `busy` is still 1 in this cycle. Next state is IDLE.
- A `start` asserted while `busy`=1 or in the FIN cycle is ignored. Nothing is queued.
- `rst_n` low mid-transaction aborts immediately: `CS_N` rises, no `done` pulse is generated, and the flash sees an aborted command.

## Timing
- Each SPI bit takes 2 clk cycles: one low phase (`CLK`=0, `MOSI` updated at the start of it), then one high phase (`CLK`=1).
- `MISO` is sampled at the clk edge that ends the high phase.
- The SPI clock rate is clk/2.
- `CS_N` falls in the same cycle as the first low phase. It rises in the cycle after the last high phase, with `CLK` already 0.
- Transaction lengths with `CS_N` low:
  - WREN: 16 cycles.
  - PROG: 128 cycles.
  - POLL: 32 cycles.
- `start` accepted at edge N: `busy`=1 and `CS_N`=0 from cycle N+1.
- Latency for an immediate-ready flash (first poll reads WIP=0):
  - 16 + `CS_GAP` + 128 + `CS_GAP` + 32 cycles, then the FIN cycle.
  - With `CS_GAP`=4 this is 184 cycles of `busy` before FIN, 185 including FIN.
- `done` rises on the cycle after the last POLL high phase completes.
- `status` updates at that same edge and holds until the next poll.
- The poll counter is 16-bit and saturates at `POLL_MAX`; it never wraps.

## Test plan
- Reset mid-PROG:
  - Stimulus: drop `rst_n` at the 40th PROG cycle.
  - Required: `CS_N`=1, `CLK`=0, `busy`=0 within the same cycle; no `done` pulse.
  - After release: idle until a new `start`.
- Basic program, flash model ready at once:
  - Stimulus: `addr`=0x012345, `wdata`=0xDEADBEEF.
  - Required MOSI byte stream: 0x06 | 0x02 01 23 45 EF BE AD DE | 0x05 00.
  - Required: `done` exactly 185 cycles after `start` (`CS_GAP`=4), `status`=0x00, `error`=0.
- Busy flash:
  - Stimulus: model returns status 0x03 for 3 polls, then 0x02.
  - Required: 4 POLL transactions, each separated by `CS_GAP` cycles of `CS_N` high.
  - Required: `done`=1 with `status`=0x02, `error`=0.
- Timeout:
  - Stimulus: `POLL_MAX`=2, model always returns 0x01.
  - Required: exactly 2 polls, then `done` and `error` high together for 1 cycle.
- Start while busy:
  - Stimulus: pulse `start` with `addr`=0x000100 during PROG.
  - Required: ignored; the ongoing transaction keeps its original address; only one `done` pulse.
- SPI protocol check throughout all tests:
  - `CLK` toggles only while `CS_N`=0.
  - `MOSI` is stable across every `CLK` high phase.
  - `CS_N` high gaps are at least `CS_GAP` cycles.
